// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller with 128-bit lines.
// Read misses fill a full line from memory in four word beats; every write goes to memory.
module cache_ctrl #(
  parameter int INDEX_W = 4,
  parameter int TAG_W   = 28 - INDEX_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sys_req,
  input  logic        sys_we,
  input  logic [31:0] sys_addr,
  input  logic [31:0] sys_wdata,
  input  logic [3:0]  sys_bval,
  output logic        sys_ack,
  output logic [31:0] sys_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_bval,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid
);

  localparam int NLINES = 1 << INDEX_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, FILL, WMEM, RESP} state_t;

  state_t             state;
  logic               we_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic [3:0]         bval_q;
  logic               hit_q;
  logic [1:0]         beat_q;
  logic [NLINES-1:0]  valid_q;

  logic [95:0]        fill_buf;
  logic [127:0]       lines [NLINES];
  logic [TAG_W-1:0]   tags  [NLINES];

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic [1:0]         off;
  logic [6:0]         word_lsb;
  logic               lookup_hit;
  logic               beat_take;
  logic               fill_done;
  logic               wr_hit_upd;
  logic [127:0]       cur_line;
  logic [31:0]        cur_word;
  logic [127:0]       filled_line;
  logic [31:0]        filled_word;
  logic [127:0]       merged_line;

  function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    logic [31:0] m;
    m = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) m[8*i +: 8] = new_w[8*i +: 8];
    end
    return m;
  endfunction

  assign idx         = addr_q[3+INDEX_W:4];
  assign tag         = addr_q[31:4+INDEX_W];
  assign off         = addr_q[3:2];
  assign word_lsb    = {off, 5'b00000};
  assign lookup_hit  = valid_q[idx] && (tags[idx] == tag);
  // Beats only count once the line read has been accepted (mem_req already dropped).
  assign beat_take   = (state == FILL) && !mem_req && mem_rvalid;
  assign fill_done   = beat_take && (beat_q == 2'd3);
  assign wr_hit_upd  = (state == WMEM) && mem_ack && hit_q;
  assign cur_line    = lines[idx];
  assign cur_word    = cur_line[word_lsb +: 32];
  assign filled_line = {mem_rdata, fill_buf};
  assign filled_word = filled_line[word_lsb +: 32];

  always_comb begin
    merged_line = cur_line;
    merged_line[word_lsb +: 32] = merge_word(cur_word, wdata_q, bval_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      bval_q    <= '0;
      hit_q     <= 1'b0;
      beat_q    <= '0;
      valid_q   <= '0;
      sys_ack   <= 1'b0;
      sys_rdata <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_bval  <= '0;
    end else begin
      case (state)
        IDLE: begin
          sys_ack <= 1'b0;
          if (sys_req) begin
            we_q    <= sys_we;
            addr_q  <= sys_addr;
            wdata_q <= sys_wdata;
            bval_q  <= sys_bval;
            state   <= LOOKUP;
          end
        end
        LOOKUP: begin
          hit_q <= lookup_hit;
          if (we_q) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= addr_q & 32'hFFFF_FFFC;
            mem_wdata <= wdata_q;
            mem_bval  <= bval_q;
            state     <= WMEM;
          end else if (lookup_hit) begin
            sys_ack   <= 1'b1;
            sys_rdata <= cur_word;
            state     <= RESP;
          end else begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= addr_q & 32'hFFFF_FFF0;
            beat_q   <= '0;
            state    <= FILL;
          end
        end
        FILL: begin
          if (mem_req && mem_ack) begin
            mem_req <= 1'b0;
          end else if (beat_take) begin
            beat_q <= beat_q + 2'd1;
            if (beat_q == 2'd3) begin
              valid_q[idx] <= 1'b1;
              sys_ack      <= 1'b1;
              sys_rdata    <= filled_word;
              state        <= RESP;
            end
          end
        end
        WMEM: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            sys_ack <= 1'b1;
            state   <= RESP;
          end
        end
        RESP: begin
          sys_ack <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line storage carries no reset; valid_q alone decides whether a line is usable.
  always_ff @(posedge clk) begin
    if (beat_take) begin
      case (beat_q)
        2'd0:    fill_buf[31:0]  <= mem_rdata;
        2'd1:    fill_buf[63:32] <= mem_rdata;
        2'd2:    fill_buf[95:64] <= mem_rdata;
        default: ;
      endcase
    end
    if (fill_done) begin
      lines[idx] <= filled_line;
      tags[idx]  <= tag;
    end else if (wr_hit_upd) begin
      lines[idx] <= merged_line;
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: reference memory plus tag/valid model feeds
// a scoreboard of expected read data and per-transaction latency checks.
module tb_cache_ctrl;
  localparam int INDEX_W = 4;
  localparam int TAG_W   = 28 - INDEX_W;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sys_req = 1'b0;
  logic        sys_we = 1'b0;
  logic [31:0] sys_addr = '0;
  logic [31:0] sys_wdata = '0;
  logic [3:0]  sys_bval = '0;
  logic        sys_ack;
  logic [31:0] sys_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_bval;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;

  always #5 clk = ~clk;

  cache_ctrl #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .sys_req(sys_req), .sys_we(sys_we), .sys_addr(sys_addr),
    .sys_wdata(sys_wdata), .sys_bval(sys_bval),
    .sys_ack(sys_ack), .sys_rdata(sys_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_bval(mem_bval),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ref_mem [int unsigned];
  logic             ref_valid [16];
  logic [TAG_W-1:0] ref_tag   [16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (ref_mem.exists(w)) return ref_mem[w];
    return w ^ 32'hC0DE_0000;
  endfunction

  task automatic chk_reset_outs();
    chk("rst_sys_ack",   32'(sys_ack),   32'd0);
    chk("rst_sys_rdata", sys_rdata,      32'd0);
    chk("rst_mem_req",   32'(mem_req),   32'd0);
    chk("rst_mem_we",    32'(mem_we),    32'd0);
    chk("rst_mem_addr",  mem_addr,       32'd0);
    chk("rst_mem_wdata", mem_wdata,      32'd0);
    chk("rst_mem_bval",  32'(mem_bval),  32'd0);
  endtask

  // Issues one request at a negedge and plays memory until sys_ack (or an abort via reset).
  task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input int ack_dly, input int gap,
                        input int abort_beats);
    logic [3:0]       idx;
    logic [TAG_W-1:0] tg;
    logic             hit;
    logic [31:0]      exp_addr;
    logic [31:0]      merged;
    int cyc, mem_rise, req_cycles, ack_cyc, beats, gap_cnt, last_beat;
    bit acked, done, aborted;
    idx = a[7:4];
    tg = a[31:8];
    hit = ref_valid[idx] && (ref_tag[idx] == tg);
    exp_addr = we ? {a[31:2], 2'b00} : {a[31:4], 4'h0};
    mem_rise = -1; req_cycles = 0; ack_cyc = -1; beats = 0; gap_cnt = 0; last_beat = -1;
    acked = 0; done = 0; aborted = 0;
    if (!we && abort_beats < 0) exp_q.push_back(mem_rd(a));
    sys_req = 1'b1; sys_we = we; sys_addr = a; sys_wdata = wd; sys_bval = be;
    @(posedge clk);
    cyc = 1;
    while (!done && cyc < 80) begin
      @(negedge clk);
      mem_ack = 1'b0;
      mem_rvalid = 1'b0;
      if (abort_beats >= 0 && acked && beats == abort_beats) begin
        rst = 1'b1;
        sys_req = 1'b0;
        #1;
        chk_reset_outs();
        done = 1;
        aborted = 1;
      end else if (sys_ack) begin
        sys_req = 1'b0;
        done = 1;
        chk("ack_latency", 32'(cyc), we ? 32'(ack_cyc + 1) : (hit ? 32'd2 : 32'(last_beat + 1)));
        chk("mem_req_rise", 32'(mem_rise), (hit && !we) ? 32'hFFFF_FFFF : 32'd2);
        chk("mem_req_at_ack", 32'(mem_req), 32'd0);
        if (!we && exp_q.size() > 0) chk("rdata", sys_rdata, exp_q.pop_front());
      end else begin
        if (acked && cyc == ack_cyc + 1) chk("mem_req_drop", 32'(mem_req), 32'd0);
        if (mem_req && !acked) begin
          if (mem_rise < 0) mem_rise = cyc;
          chk("mem_we", 32'(mem_we), 32'(we));
          chk("mem_addr", mem_addr, exp_addr);
          if (we) begin
            chk("mem_wdata", mem_wdata, wd);
            chk("mem_bval", 32'(mem_bval), 32'(be));
          end
          req_cycles++;
          if (req_cycles > ack_dly) begin
            mem_ack = 1'b1;
            acked = 1;
            ack_cyc = cyc;
          end
        end else if (acked && !we && beats < 4) begin
          if (gap_cnt < gap) begin
            gap_cnt++;
          end else begin
            mem_rvalid = 1'b1;
            mem_rdata = mem_rd({a[31:4], 4'h0} + 32'(beats * 4));
            beats++;
            gap_cnt = 0;
            last_beat = cyc;
          end
        end
      end
      cyc++;
    end
    chk("completed", 32'(done), 32'd1);
    if (aborted) begin
      for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
      @(negedge clk);
      rst = 1'b0;
    end else if (we) begin
      merged = mem_rd(a);
      for (int i = 0; i < 4; i++) if (be[i]) merged[8*i +: 8] = wd[8*i +: 8];
      ref_mem[{a[31:2], 2'b00}] = merged;
    end else if (!hit) begin
      ref_valid[idx] = 1'b1;
      ref_tag[idx] = tg;
    end
    @(negedge clk);
  endtask

  task automatic idle_noise(input int n);
    for (int i = 0; i < n; i++) begin
      mem_rvalid = 1'b1;
      mem_ack = 1'b1;
      mem_rdata = $urandom;
      @(negedge clk);
      chk("idle_sys_ack", 32'(sys_ack), 32'd0);
      chk("idle_mem_req", 32'(mem_req), 32'd0);
    end
    mem_rvalid = 1'b0;
    mem_ack = 1'b0;
  endtask

  initial begin
    logic [31:0] ra;
    for (int i = 0; i < 16; i++) begin
      ref_valid[i] = 1'b0;
      ref_tag[i] = '0;
    end
    ref_mem[32'h10] = 32'h0000_00A0;
    ref_mem[32'h14] = 32'h0000_00A1;
    ref_mem[32'h18] = 32'h0000_00A2;
    ref_mem[32'h1C] = 32'h0000_00A3;

    #2 rst = 1'b1;
    @(negedge clk);
    chk_reset_outs();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_req(1'b0, 32'h0000_0014, 32'h0, 4'h0, 0, 0, -1);
    do_req(1'b0, 32'h0000_0018, 32'h0, 4'h0, 0, 0, -1);
    do_req(1'b1, 32'h0000_0014, 32'h1122_3344, 4'b0101, 0, 0, -1);
    do_req(1'b0, 32'h0000_0014, 32'h0, 4'h0, 0, 0, -1);
    chk("merge_word", mem_rd(32'h14), 32'h0022_0044);

    do_req(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 1, 0, -1);
    do_req(1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 1, -1);

    do_req(1'b0, 32'h0000_0110, 32'h0, 4'h0, 2, 0, -1);
    do_req(1'b0, 32'h0000_0010, 32'h0, 4'h0, 0, 2, -1);

    do_req(1'b1, 32'h0000_0018, 32'h5566_7788, 4'b0000, 0, 0, -1);
    do_req(1'b0, 32'h0000_0018, 32'h0, 4'h0, 0, 0, -1);

    do_req(1'b0, 32'h0000_0204, 32'h0, 4'h0, 0, 0, 2);
    do_req(1'b0, 32'h0000_0204, 32'h0, 4'h0, 0, 0, -1);

    do_req(1'b0, 32'h0000_001C, 32'h0, 4'h0, 0, 0, -1);
    idle_noise(4);
    do_req(1'b1, 32'h0000_001C, 32'hA5A5_5A5A, 4'b1010, 5, 0, -1);
    idle_noise(3);
    do_req(1'b0, 32'h0000_001C, 32'h0, 4'h0, 0, 0, -1);

    for (int k = 0; k < 12; k++) begin
      ra = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 3)) << 4) |
           (32'($urandom_range(0, 3)) << 2);
      do_req(1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom_range(0, 15)),
             $urandom_range(0, 3), $urandom_range(0, 2), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
